conv_window_sum: RTL and testbench
==================================

CONV_WINDOW_SUM -- requirements
Module: conv_window_sum

Interface
REQ-001 Parameter WIDTH, default 16: pixel and result bit width.
REQ-002 Parameter IMG_W, default 64: pixels per image row; SHALL be >= K.
REQ-003 Parameter IMG_H, default 64: rows per frame; SHALL be >= K.
REQ-004 Parameter K, default 3: square window edge; SHALL be >= 2.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 clear  input  1  synchronous frame restart, active-high.
REQ-009 in_valid  input  1  in_data holds a pixel.
REQ-010 in_ready  output  1  block accepts the pixel this cycle.
REQ-011 in_data  input  WIDTH  raster-order pixel.
REQ-012 out_valid  output  1  out_data holds a window sum.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  WIDTH  KxK window sum.
REQ-015 out_last  output  1  qualifies the final result of a frame.

Function
REQ-016 Accept: a pixel is accepted on a rising clk edge with in_valid=1 and in_ready=1.
REQ-017 Accept condition: in_ready SHALL equal (!out_valid || out_ready); the path is combinational, with no dependence on in_valid.
REQ-018 Position counters: column x (0..IMG_W-1) and row y (0..IMG_H-1) SHALL advance only on an accept.
REQ-019 Counter wrap: x wraps to 0 and increments y; at (IMG_W-1, IMG_H-1) both counters SHALL wrap to 0, and the next accepted pixel starts a new frame.
REQ-020 Line buffers: K-1 internal row buffers of IMG_W x WIDTH each SHALL hold the previous K-1 rows; they are written only on an accept.
REQ-021 Window registers: a KxK window register array SHALL shift one column per accept, loaded from the row buffers plus in_data.
REQ-022 Result value: accepting pixel (x,y) with x>=K-1 and y>=K-1 SHALL produce sum over i,j in [0,K-1] of p(x-i, y-j), truncated modulo 2^WIDTH (wrap, no saturation).
REQ-023 Windows that straddle a row boundary or the top K-1 rows SHALL produce no output.
REQ-024 Latency: out_valid SHALL rise on the clk edge that accepts the completing pixel, giving exactly one register stage from in_data to out_data.
REQ-025 Output hold: while out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold stable and in_ready SHALL be 0.
REQ-026 Simultaneous events: if out_ready=1 and a new result is produced in the same cycle, the output register SHALL load the new result with no bubble; otherwise out_valid clears when out_ready=1.
REQ-027 Frame count: each frame SHALL yield exactly (IMG_W-K+1)*(IMG_H-K+1) results in raster order.
REQ-028 Frame end: out_last SHALL be 1 only on the result for pixel (IMG_W-1, IMG_H-1).
REQ-029 clear=1 SHALL zero x, y, out_valid and out_last on the next edge and SHALL discard any pending output.
REQ-030 clear has priority over an accept in the same cycle; that pixel is dropped.

Reset
REQ-031 While rst_n=0: out_valid=0, out_data=0, out_last=0, x=0, y=0, window registers 0; in_ready therefore reads 1.
REQ-032 Line buffer contents are not reset; outputs SHALL never depend on stale contents, because results are gated by REQ-022/023.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; the first pixel after rst_n deasserts is pixel (0,0).

Verification (IMG_W=IMG_H=4, K=3, WIDTH=16 unless stated)
REQ-034 All pixels 1, out_ready=1 -> exactly 4 results of 9 each; out_last set on the 4th only.
REQ-035 Pixel value p = x+4y -> results 45, 54, 81, 90 in that order.
REQ-036 All pixels 0xFFFF -> every result 0xFFF7 (modulo wrap).
REQ-037 out_ready=0 for 5 cycles at the first result -> out_data holds 45 and in_ready=0 throughout; no pixel is lost and the remaining results still read 54, 81, 90.
REQ-038 rst_n pulsed low after 7 accepted pixels, then a full ramp frame is sent -> the output matches REQ-035 exactly.
REQ-039 clear asserted after 10 pixels, then a full frame is sent -> exactly 4 results, all from the new frame.

Source files
------------

// File: rtl/conv_window_sum.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_sum
//  Purpose  : Streaming KxK box-sum over a raster-order image. K-1 line
//             buffers hold previous rows; a KxK window register shifts one
//             column per accepted pixel and the window sum is registered
//             into a single-entry valid/ready output stage.
//  Revision : 1.0  initial release
// ============================================================================
module conv_window_sum #(
   parameter int WIDTH = 16,
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int K     = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
   localparam logic [XW-1:0] X_FIRST = XW'(K - 1);
   localparam logic [YW-1:0] Y_FIRST = YW'(K - 1);

   logic [XW-1:0]    x_q, x_d;
   logic [YW-1:0]    y_q, y_d;
   logic [WIDTH-1:0] win_q [K][K];   // [row][col], row 0 = current row, col 0 = newest
   logic [WIDTH-1:0] win_d [K][K];
   logic [WIDTH-1:0] line_buf_q [K-1][IMG_W];   // row 0 = previous image row
   logic [WIDTH-1:0] new_col [K];
   logic [WIDTH-1:0] win_sum;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_last_q, out_last_d;
   logic             accept;
   logic             pix_take;
   logic             produce;

   // Handshake: a result is pending only while downstream has not taken it.
   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   // A clear in the same cycle drops the pixel entirely.
   assign pix_take  = accept && !clear;
   // Only windows fully inside the current and previous K-1 rows emit a result.
   assign produce   = pix_take && (x_q >= X_FIRST) && (y_q >= Y_FIRST);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

   // Column entering the window: new pixel plus the same column of older rows.
   always_comb begin
      new_col[0] = in_data;
      for (int r = 1; r < K; r++) begin
         new_col[r] = line_buf_q[r-1][x_q];
      end
   end

   // Next window: shift one column on each taken pixel, otherwise hold.
   always_comb begin
      for (int r = 0; r < K; r++) begin
         win_d[r][0] = pix_take ? new_col[r] : win_q[r][0];
         for (int c = 1; c < K; c++) begin
            win_d[r][c] = pix_take ? win_q[r][c-1] : win_q[r][c];
         end
      end
   end

   // Sum of the window as it stands after this pixel, wrapping modulo 2^WIDTH.
   always_comb begin
      win_sum = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            win_sum = win_sum + win_d[r][c];
         end
      end
   end

   // Raster position counters advance on every taken pixel and wrap per frame.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear) begin
         x_d = '0;
         y_d = '0;
      end else if (accept) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   // Output stage: load a new result (even while the old one drains), else
   // retire the held result when downstream takes it.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (clear) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else if (produce) begin
         out_valid_d = 1'b1;
         out_data_d  = win_sum;
         out_last_d  = (x_q == X_LAST) && (y_q == Y_LAST);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   // Control, window and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q         <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         win_q       <= win_d;
      end
   end

   // Line buffers behave as RAM: no reset, each row shifts down one buffer.
   always_ff @(posedge clk) begin
      if (pix_take) begin
         for (int r = 0; r < K - 1; r++) begin
            line_buf_q[r][x_q] <= new_col[r];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_window_sum
//  Purpose  : Self-checking bench for conv_window_sum (4x4 image, K=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_window_sum;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int KK = 3;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            nres     = 0;
   int            rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
   bit            bubbles  = 1'b0;
   logic [DW-1:0] pix [W*H];
   logic [DW:0]   exp_q [$];      // {last, data}

   conv_window_sum #(.WIDTH(DW), .IMG_W(W), .IMG_H(H), .K(KK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Downstream readiness driven one delta after each rising edge.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // Scoreboard: a handshake visible at the falling edge completes on the next rise.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         nres++;
         if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            logic [DW:0] e;
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e[DW-1:0]));
            check("out_last", 32'(out_last), 32'(e[DW]));
         end
      end
   end

   task automatic make_frame(input int kind);
      for (int i = 0; i < W*H; i++) begin
         case (kind)
            1:       pix[i] = DW'(i);
            2:       pix[i] = 16'd1;
            3:       pix[i] = 16'hFFFF;
            default: pix[i] = DW'($urandom_range(0, 65535));
         endcase
      end
   endtask

   // Reference: plain window sums over the stored frame, raster order.
   task automatic push_expected();
      for (int y = KK - 1; y < H; y++) begin
         for (int x = KK - 1; x < W; x++) begin
            int s;
            logic [DW:0] e;
            s = 0;
            for (int j = 0; j < KK; j++)
               for (int i = 0; i < KK; i++)
                  s += int'(pix[(y-j)*W + (x-i)]);
            e = {((x == W-1) && (y == H-1)), s[DW-1:0]};
            exp_q.push_back(e);
         end
      end
   endtask

   // Sends the first n pixels of pix; entry and exit at one delta past a rising edge.
   task automatic send(input int n);
      for (int i = 0; i < n; i++) begin
         int t;
         bit done;
         if (bubbles) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         in_data  = pix[i];
         t        = 0;
         done     = 1'b0;
         while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
            t++;
            if (!done && t > 200) begin
               check("accept_timeout", 32'(t), 32'd0);
               done = 1'b1;
            end
         end
         in_valid = 1'b0;
      end
   endtask

   task automatic drain(input int exp_n);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("result_count", 32'(nres), 32'(exp_n));
   endtask

   task automatic full_frame(input int kind);
      nres = 0;
      make_frame(kind);
      push_expected();
      send(W*H);
      drain((W-KK+1)*(H-KK+1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_last",  32'(out_last),  32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end

      // Directed frames: all ones, ramp, all 0xFFFF (back to back).
      full_frame(2);
      full_frame(1);
      full_frame(3);

      // Stall at the first ramp result for five cycles.
      rdy_mode = 2;
      repeat (2) begin
         @(posedge clk); #1;
      end
      nres = 0;
      make_frame(1);
      push_expected();
      fork
         send(W*H);
         begin
            int t;
            t = 0;
            @(negedge clk);
            while (!out_valid && t < 100) begin
               @(negedge clk);
               t++;
            end
            check("stall_seen", 32'(out_valid), 32'd1);
            for (int k = 0; k < 5; k++) begin
               check("stall_data",     32'(out_data),  32'd45);
               check("stall_in_ready", 32'(in_ready),  32'd0);
               check("stall_valid",    32'(out_valid), 32'd1);
               @(negedge clk);
            end
            rdy_mode = 0;
         end
      join
      drain(4);

      // Reset pulsed mid-frame, then a ramp frame.
      make_frame(0);
      send(7);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_data",  32'(out_data),  32'd0);
      check("mid_rst_out_last",  32'(out_last),  32'd0);
      check("mid_rst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      full_frame(1);

      // Clear after 10 pixels; the pixel presented with clear is dropped.
      make_frame(0);
      send(10);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      full_frame(0);

      // Clear discards a pending result.
      rdy_mode = 2;
      repeat (2) begin
         @(posedge clk); #1;
      end
      make_frame(0);
      send(11);
      @(negedge clk);
      check("pend_out_valid", 32'(out_valid), 32'd1);
      check("pend_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      @(negedge clk);
      check("clr_out_valid", 32'(out_valid), 32'd0);
      check("clr_out_last",  32'(out_last),  32'd0);
      rdy_mode = 0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      full_frame(0);

      // Random frames with input bubbles and random backpressure.
      rdy_mode = 1;
      bubbles  = 1'b1;
      for (int f = 0; f < 5; f++) begin
         full_frame(0);
      end
      rdy_mode = 0;
      bubbles  = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
